spi_shift_engine: RTL and testbench



---
 rtl/spi_shift_engine.sv | 193 +++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : SPI mode-0 (CPOL=0, CPHA=0) shift engine. Serialises 1-4
//               bytes of a 32-bit word on MOSI/SCLK (byte 0 first, MSB first
//               within each byte) and assembles MISO into a 32-bit read word
//               with a running received-byte fill level.
// Ports       : clk_i, rstn_i                 - clock, async active-low reset
//               enable_i                      - start / continue request
//               spi_write_data_i[31:0]        - transmit word
//               spi_write_data_bytes_valid_i  - bytes to send (1-4)
//               reset_fill_level_i            - clear fill level (IDLE/TAIL)
//               spi_miso_i                    - serial data from slave
//               spi_mosi_o, spi_clk_o         - serial data / SCLK to slave
//               spi_read_data_o[31:0]         - received word
//               spi_read_data_bytes_valid_o   - received-byte fill level 0-4
//               ready_o                       - idle, can accept a start
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        enable_i,
    input  logic [31:0] spi_write_data_i,
    input  logic [2:0]  spi_write_data_bytes_valid_i,
    input  logic        reset_fill_level_i,
    input  logic        spi_miso_i,
    output logic        spi_mosi_o,
    output logic        spi_clk_o,
    output logic [31:0] spi_read_data_o,
    output logic [2:0]  spi_read_data_bytes_valid_o,
    output logic        ready_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHIFT    = 2'd1;
    localparam logic [1:0] TAIL     = 2'd2;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [1:0]  state_q,  state_d;
    logic [7:0]  div_q,    div_d;
    logic [2:0]  bit_q,    bit_d;
    logic [1:0]  byte_q,   byte_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [31:0] tx_q,     tx_d;
    logic [7:0]  rx_q,     rx_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [2:0]  fill_q,   fill_d;
    logic        sclk_q,   sclk_d;
    logic        mosi_q,   mosi_d;
    logic        ready_q,  ready_d;

    logic start_req;
    logic div_term;
    logic sclk_rise;
    logic sclk_fall;
    logic byte_done;
    logic last_byte;

    assign start_req = enable_i && (spi_write_data_bytes_valid_i != 3'd0)
                                && (spi_write_data_bytes_valid_i <= 3'd4);
    assign div_term  = (div_q == DIV_LAST);
    // SCLK edges are defined by the registered level about to toggle
    assign sclk_rise = (state_q == SHIFT) && div_term && !sclk_q;
    assign sclk_fall = (state_q == SHIFT) && div_term &&  sclk_q;
    assign byte_done = sclk_fall && (bit_q == 3'd7);
    // Enable is only consulted at byte boundaries; a byte always completes
    assign last_byte = (({1'b0, byte_q} + 3'd1) == nbytes_q) || !enable_i;

    // State register (plus datapath flops)
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            div_q    <= 8'd0;
            bit_q    <= 3'd0;
            byte_q   <= 2'd0;
            nbytes_q <= 3'd0;
            tx_q     <= 32'd0;
            rx_q     <= 8'd0;
            rdata_q  <= 32'd0;
            fill_q   <= 3'd0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            nbytes_q <= nbytes_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            fill_q   <= fill_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_req)              state_d = SHIFT;
            SHIFT:   if (byte_done && last_byte) state_d = TAIL;
            TAIL:    if (div_term)               state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        div_d    = div_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        nbytes_d = nbytes_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        fill_d   = fill_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        ready_d  = (state_d == IDLE);

        case (state_q)
            IDLE: begin
                div_d  = 8'd0;
                sclk_d = 1'b0;
                if (start_req) begin
                    tx_d     = spi_write_data_i;
                    nbytes_d = spi_write_data_bytes_valid_i;
                    bit_d    = 3'd0;
                    byte_d   = 2'd0;
                    rx_d     = 8'd0;
                    rdata_d  = 32'd0;
                    fill_d   = 3'd0;
                    mosi_d   = spi_write_data_i[7];
                end else if (reset_fill_level_i) begin
                    fill_d = 3'd0;
                end
            end
            SHIFT: begin
                div_d = div_term ? 8'd0 : div_q + 8'd1;
                if (div_term) sclk_d = !sclk_q;
                if (sclk_rise) rx_d = {rx_q[6:0], spi_miso_i};
                if (sclk_fall) begin
                    if (bit_q == 3'd7) begin
                        for (int k = 0; k < 4; k++) begin
                            if (byte_q == 2'(k)) rdata_d[8*k +: 8] = rx_q;
                        end
                        fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
                        if (last_byte) begin
                            mosi_d = 1'b0;
                        end else begin
                            // Next byte moves into the low lane; its MSB goes
                            // out immediately so SCLK runs without a gap
                            byte_d = byte_q + 2'd1;
                            bit_d  = 3'd0;
                            tx_d   = {8'd0, tx_q[31:8]};
                            mosi_d = tx_q[15];
                        end
                    end else begin
                        bit_d      = bit_q + 3'd1;
                        tx_d[7:0]  = {tx_q[6:0], 1'b0};
                        mosi_d     = tx_q[6];
                    end
                end
            end
            TAIL: begin
                div_d  = div_term ? 8'd0 : div_q + 8'd1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (reset_fill_level_i) fill_d = 3'd0;
            end
            default: begin
                div_d  = 8'd0;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
            end
        endcase
    end

    assign spi_mosi_o                  = mosi_q;
    assign spi_clk_o                   = sclk_q;
    assign spi_read_data_o             = rdata_q;
    assign spi_read_data_bytes_valid_o = fill_q;
    assign ready_o                     = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_shift_engine
// Description : Self-checking bench for spi_shift_engine (CLK_DIV=2). A
//               behavioural mode-0 slave drives MISO (or loops MOSI back);
//               expected words, fill levels and latencies come from the
//               byte-level transfer rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_shift_engine;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [2:0]  nbytes = 3'd0;
    logic        reset_fill = 1'b0;
    logic        spi_miso;
    logic        spi_mosi;
    logic        spi_clk;
    logic [31:0] rdata;
    logic [2:0]  fill;
    logic        ready;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          loopback = 1'b0;
    logic [31:0] slave_word = 32'd0;
    int          slave_idx = 0;

    // Mode-0 slave: byte 0 first, MSB first; bit i is shifted out after the
    // i-th SCLK falling edge
    function automatic logic slave_bit(input logic [31:0] w, input int i);
        if (i > 31) return 1'b0;
        return w[(i / 8) * 8 + 7 - (i % 8)];
    endfunction

    assign spi_miso = loopback ? spi_mosi : slave_bit(slave_word, slave_idx);

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i                        (clk),
        .rstn_i                       (rstn),
        .enable_i                     (enable),
        .spi_write_data_i             (wdata),
        .spi_write_data_bytes_valid_i (nbytes),
        .reset_fill_level_i           (reset_fill),
        .spi_miso_i                   (spi_miso),
        .spi_mosi_o                   (spi_mosi),
        .spi_clk_o                    (spi_clk),
        .spi_read_data_o              (rdata),
        .spi_read_data_bytes_valid_o  (fill),
        .ready_o                      (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] byte_mask(input int c);
        logic [31:0] m = 32'd0;
        for (int k = 0; k < c; k++) m[8*k +: 8] = 8'hFF;
        return m;
    endfunction

    // Runs one transfer; enable is held until the fill level reaches drop_at.
    task automatic run_xfer(input logic [31:0] data, input logic [2:0] nb,
                            input int drop_at, output int lat, output int rises,
                            output logic [31:0] mosi_word, output int min_gap,
                            output int max_gap, output int fill_code,
                            output bit timeout);
        int start_cyc, last_rise, gap, pos;
        logic prev_sclk, fill_prev;
        logic [2:0] fprev;
        slave_idx = 0;
        @(negedge clk);
        enable = 1'b1; wdata = data; nbytes = nb;
        @(posedge clk);
        @(negedge clk);
        start_cyc = cyc;
        wdata = ~data;
        prev_sclk = 1'b0; rises = 0; mosi_word = 32'd0; min_gap = 1000000;
        max_gap = 0; fill_code = 0; fprev = 3'd0; timeout = 1'b0; last_rise = 0;
        fill_prev = 1'b0;
        while (!ready) begin
            if (spi_clk && !prev_sclk) begin
                pos = (rises / 8) * 8 + 7 - (rises % 8);
                if (rises < 32) mosi_word[pos] = spi_mosi;
                if (rises > 0) begin
                    gap = cyc - last_rise;
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                end
                last_rise = cyc;
                rises++;
            end
            if (!spi_clk && prev_sclk) slave_idx++;
            prev_sclk = spi_clk;
            if (fill != fprev) begin
                fill_code = fill_code * 8 + int'(fill);
                fprev = fill;
            end
            if (int'(fill) >= drop_at) enable = 1'b0;
            if (cyc - start_cyc > 2000) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
        end
        lat = cyc - start_cyc;
        enable = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else n_pass++;
        n_checks++; if (spi_clk !== 1'b0) $display("FAIL reset_sclk got=%b exp=0", spi_clk); else n_pass++;
        n_checks++; if (spi_mosi !== 1'b0) $display("FAIL reset_mosi got=%b exp=0", spi_mosi); else n_pass++;
        n_checks++; if (rdata !== 32'd0) $display("FAIL reset_rdata got=%h exp=0", rdata); else n_pass++;
        n_checks++; if (fill !== 3'd0) $display("FAIL reset_fill got=%0d exp=0", fill); else n_pass++;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loop_a5();
        int lat, rises, ming, maxg, fc; logic [31:0] mw; bit to;
        loopback = 1'b1;
        run_xfer(32'h0000_00A5, 3'd1, 1, lat, rises, mw, ming, maxg, fc, to);
        n_checks++; if (to) $display("FAIL a5_timeout waited=%0d cycles", lat); else n_pass++;
        n_checks++; if (mw !== 32'h0000_00A5) $display("FAIL a5_mosi got=%h exp=000000a5", mw); else n_pass++;
        n_checks++; if (rises !== 8) $display("FAIL a5_pulses got=%0d exp=8", rises); else n_pass++;
        n_checks++; if (rdata !== 32'h0000_00A5) $display("FAIL a5_rdata got=%h exp=000000a5", rdata); else n_pass++;
        n_checks++; if (fill !== 3'd1) $display("FAIL a5_fill got=%0d exp=1", fill); else n_pass++;
        n_checks++; if (lat !== 34) $display("FAIL a5_latency got=%0d exp=34", lat); else n_pass++;
    endtask

    task automatic test_four_bytes();
        int lat, rises, ming, maxg, fc; logic [31:0] mw; bit to;
        loopback = 1'b0; slave_word = 32'hFFFF_FFFF;
        run_xfer(32'h1122_3344, 3'd4, 4, lat, rises, mw, ming, maxg, fc, to);
        n_checks++; if (to) $display("FAIL four_timeout waited=%0d cycles", lat); else n_pass++;
        n_checks++; if (mw !== 32'h1122_3344) $display("FAIL four_mosi_order got=%h exp=11223344", mw); else n_pass++;
        // fill steps 1,2,3,4 encoded as octal digits
        n_checks++; if (fc !== 668) $display("FAIL four_fill_steps got=%0o exp=1234", fc); else n_pass++;
        n_checks++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL four_rdata got=%h exp=ffffffff", rdata); else n_pass++;
        n_checks++; if (rises !== 32) $display("FAIL four_pulses got=%0d exp=32", rises); else n_pass++;
        n_checks++; if (ming !== 2*CLK_DIV || maxg !== 2*CLK_DIV)
            $display("FAIL four_gap got=%0d..%0d exp=%0d", ming, maxg, 2*CLK_DIV); else n_pass++;
        n_checks++; if (lat !== 65*CLK_DIV) $display("FAIL four_latency got=%0d exp=%0d", lat, 65*CLK_DIV); else n_pass++;
    endtask

    task automatic test_enable_drop();
        int lat, rises, ming, maxg, fc; logic [31:0] mw; bit to;
        loopback = 1'b0; slave_word = $urandom;
        run_xfer($urandom, 3'd3, 1, lat, rises, mw, ming, maxg, fc, to);
        n_checks++; if (to) $display("FAIL drop_timeout waited=%0d cycles", lat); else n_pass++;
        n_checks++; if (fill !== 3'd2) $display("FAIL drop_fill got=%0d exp=2", fill); else n_pass++;
        n_checks++; if (rises !== 16) $display("FAIL drop_pulses got=%0d exp=16", rises); else n_pass++;
        n_checks++; if (rdata !== (slave_word & 32'h0000_FFFF))
            $display("FAIL drop_rdata got=%h exp=%h", rdata, slave_word & 32'h0000_FFFF); else n_pass++;
        n_checks++; if (lat !== 33*CLK_DIV) $display("FAIL drop_latency got=%0d exp=%0d", lat, 33*CLK_DIV); else n_pass++;
    endtask

    task automatic test_invalid_count();
        int bad_vals[4] = '{0, 5, 6, 7};
        logic [2:0] fill0; logic [31:0] rd0; bit busy, pulsed;
        fill0 = fill; rd0 = rdata;
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            nbytes = 3'(bad_vals[v]); enable = 1'b1; wdata = $urandom;
            busy = 1'b0; pulsed = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (!ready) busy = 1'b1;
                if (spi_clk) pulsed = 1'b1;
            end
            enable = 1'b0;
            n_checks++; if (busy) $display("FAIL invalid_ready nb=%0d got=busy exp=ready", bad_vals[v]); else n_pass++;
            n_checks++; if (pulsed) $display("FAIL invalid_sclk nb=%0d got=pulse exp=none", bad_vals[v]); else n_pass++;
            n_checks++; if (fill !== fill0 || rdata !== rd0)
                $display("FAIL invalid_hold nb=%0d got=%0d/%h exp=%0d/%h", bad_vals[v], fill, rdata, fill0, rd0); else n_pass++;
        end
    endtask

    task automatic test_random();
        int lat, rises, ming, maxg, fc, drop, c; logic [31:0] mw, data, mask, exp_rd;
        logic [2:0] nb; bit to;
        for (int t = 0; t < 10; t++) begin
            data = $urandom; nb = 3'($urandom_range(4, 1)); drop = $urandom_range(4, 0);
            loopback = 1'($urandom_range(1, 0)); slave_word = $urandom;
            c = (drop + 1 < int'(nb)) ? drop + 1 : int'(nb);
            mask = byte_mask(c);
            exp_rd = (loopback ? data : slave_word) & mask;
            run_xfer(data, nb, drop, lat, rises, mw, ming, maxg, fc, to);
            n_checks++; if (to) $display("FAIL rand%0d_timeout waited=%0d cycles", t, lat); else n_pass++;
            n_checks++; if (rdata !== exp_rd) $display("FAIL rand%0d_rdata got=%h exp=%h", t, rdata, exp_rd); else n_pass++;
            n_checks++; if (mw !== (data & mask)) $display("FAIL rand%0d_mosi got=%h exp=%h", t, mw, data & mask); else n_pass++;
            n_checks++; if (int'(fill) !== c) $display("FAIL rand%0d_fill got=%0d exp=%0d", t, fill, c); else n_pass++;
            n_checks++; if (lat !== (16*c + 1) * CLK_DIV)
                $display("FAIL rand%0d_latency got=%0d exp=%0d", t, lat, (16*c + 1) * CLK_DIV); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, rises, ming, maxg, fc; logic [31:0] mw, d1, d2; bit to;
        loopback = 1'b1; d1 = $urandom; d2 = $urandom;
        run_xfer(d1, 3'd4, 4, lat, rises, mw, ming, maxg, fc, to);
        run_xfer(d2, 3'd1, 1, lat, rises, mw, ming, maxg, fc, to);
        n_checks++; if (to) $display("FAIL b2b_timeout waited=%0d cycles", lat); else n_pass++;
        n_checks++; if (rdata !== {24'd0, d2[7:0]}) $display("FAIL b2b_rdata got=%h exp=%h", rdata, {24'd0, d2[7:0]}); else n_pass++;
        n_checks++; if (fill !== 3'd1) $display("FAIL b2b_fill got=%0d exp=1", fill); else n_pass++;
    endtask

    task automatic test_fill_clear();
        int lat, rises, ming, maxg, fc; logic [31:0] mw, rd0; bit to;
        loopback = 1'b1;
        run_xfer($urandom, 3'd2, 2, lat, rises, mw, ming, maxg, fc, to);
        n_checks++; if (fill !== 3'd2) $display("FAIL clr_pre_fill got=%0d exp=2", fill); else n_pass++;
        rd0 = rdata;
        @(negedge clk); reset_fill = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (fill !== 3'd0) $display("FAIL clr_fill got=%0d exp=0", fill); else n_pass++;
        @(negedge clk); reset_fill = 1'b0;
        n_checks++; if (rdata !== rd0) $display("FAIL clr_rdata got=%h exp=%h", rdata, rd0); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL clr_ready got=%b exp=1", ready); else n_pass++;
    endtask

    task automatic test_async_reset();
        int lat, rises, ming, maxg, fc, n; logic [31:0] mw, d; bit to;
        loopback = 1'b0; slave_word = $urandom; slave_idx = 0;
        @(negedge clk); enable = 1'b1; wdata = $urandom; nbytes = 3'd3;
        n = 0;
        while (fill != 3'd1 && n < 500) begin @(negedge clk); n++; end
        n_checks++; if (n >= 500) $display("FAIL arst_wait_fill got=%0d exp=1", fill); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (ready !== 1'b0) $display("FAIL arst_busy got=%b exp=0", ready); else n_pass++;
        #2; rstn = 1'b0; enable = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1 || spi_clk !== 1'b0 || spi_mosi !== 1'b0 || rdata !== 32'd0 || fill !== 3'd0)
            $display("FAIL arst_outputs got=r%b c%b m%b %h f%0d exp=r1 c0 m0 0 f0", ready, spi_clk, spi_mosi, rdata, fill);
        else n_pass++;
        @(negedge clk); rstn = 1'b1;
        loopback = 1'b1; d = $urandom;
        run_xfer(d, 3'd1, 1, lat, rises, mw, ming, maxg, fc, to);
        n_checks++; if (rdata !== {24'd0, d[7:0]} || fill !== 3'd1)
            $display("FAIL arst_after got=%h/%0d exp=%h/1", rdata, fill, {24'd0, d[7:0]}); else n_pass++;
        n_checks++; if (lat !== 17*CLK_DIV) $display("FAIL arst_latency got=%0d exp=%0d", lat, 17*CLK_DIV); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_loop_a5();
        test_four_bytes();
        test_enable_drop();
        test_invalid_count();
        test_random();
        test_back_to_back();
        test_fill_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
